// File: rtl/ram_pkg.sv
// Shared types and default sizes for the RAM burst master and its response FIFO.
package ram_pkg;
  localparam int ADDR_DEF   = 8;
  localparam int DATA_DEF   = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/ram_burst_master_if.sv
// Request / write-beat / read-beat handshakes between a requester and the burst master.
interface ram_burst_master_if
  import ram_pkg::*;
#(
  parameter int ADDR  = ADDR_DEF,
  parameter int DATA  = DATA_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ADDR-1:0]  req_addr;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [DATA-1:0]  wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [DATA-1:0]  rd_data;
  logic             done;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, done
  );
endinterface

// File: rtl/ram_rsp_fifo.sv
// Show-ahead response FIFO for read data; occupancy feeds the master's issue credit.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int DATA  = DATA_DEF,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA-1:0]            push_data,
  input  logic                       pop,
  output logic [DATA-1:0]            head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // DEPTH is a power of two, so the pointers wrap on their own.
  logic [DATA-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign occupancy = count_reg;
endmodule

// File: rtl/ram_burst_master.sv
// Burst master: turns one request into a run of single-beat RAM writes or
// pipelined RAM reads, with read data buffered in a small response FIFO.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int ADDR  = ADDR_DEF,
  parameter int DATA  = DATA_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_burst_master_if.slave bus,
  output logic              ram_write_enable,
  output logic [ADDR-1:0]   ram_address,
  output logic [DATA-1:0]   ram_data_in,
  input  logic [DATA-1:0]   ram_data_out
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t           state_reg, state_next;
  logic [ADDR-1:0]  cur_reg, cur_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic             ram_we_reg, ram_we_next;
  logic [ADDR-1:0]  ram_addr_reg, ram_addr_next;
  logic [DATA-1:0]  ram_din_reg, ram_din_next;
  logic             last_wr_reg, last_wr_next;
  logic             done_wr_reg;
  logic [1:0]       inflight_reg;
  logic             issue, drain_done, credit;
  logic             fifo_empty, fifo_pop;
  logic [OCC_W-1:0] fifo_occ, pending;

  // Reads still in the RAM pipeline count against FIFO space, so the FIFO cannot overflow.
  assign pending = fifo_occ + OCC_W'(inflight_reg[0]) + OCC_W'(inflight_reg[1]);
  assign credit  = (pending < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    rem_next      = rem_reg;
    ram_we_next   = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_din_next  = ram_din_reg;
    last_wr_next  = 1'b0;
    issue         = 1'b0;
    drain_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_write) begin
            cur_next   = bus.req_addr;
            rem_next   = bus.req_len;
            state_next = WR;
          end else begin
            // The first read goes out on the accept edge to shave a cycle of latency.
            issue         = 1'b1;
            ram_addr_next = bus.req_addr;
            cur_next      = bus.req_addr + ADDR'(1);
            rem_next      = bus.req_len - LEN_W'(1);
            state_next    = (bus.req_len == '0) ? DRAIN : RD;
          end
        end
      end
      WR: begin
        if (bus.wr_valid) begin
          ram_we_next   = 1'b1;
          ram_addr_next = cur_reg;
          ram_din_next  = bus.wr_data;
          cur_next      = cur_reg + ADDR'(1);
          rem_next      = rem_reg - LEN_W'(1);
          if (rem_reg == '0) begin
            last_wr_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      RD: begin
        if (credit) begin
          issue         = 1'b1;
          ram_addr_next = cur_reg;
          cur_next      = cur_reg + ADDR'(1);
          rem_next      = rem_reg - LEN_W'(1);
          if (rem_reg == '0) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight_reg == '0) && fifo_empty) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cur_reg      <= '0;
      rem_reg      <= '0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      last_wr_reg  <= 1'b0;
      done_wr_reg  <= 1'b0;
      inflight_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      rem_reg      <= rem_next;
      ram_we_reg   <= ram_we_next;
      ram_addr_reg <= ram_addr_next;
      ram_din_reg  <= ram_din_next;
      last_wr_reg  <= last_wr_next;
      done_wr_reg  <= last_wr_reg;
      inflight_reg <= {inflight_reg[0], issue};
    end
  end

  // Stage 1 of the in-flight chain marks the cycle ram_data_out holds that read's data.
  ram_rsp_fifo #(
    .DATA  (DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg[1]),
    .push_data (ram_data_out),
    .pop       (fifo_pop),
    .head      (bus.rd_data),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign fifo_pop         = bus.rd_valid && bus.rd_ready;
  assign bus.rd_valid     = !fifo_empty;
  assign bus.req_ready    = (state_reg == IDLE);
  assign bus.wr_ready     = (state_reg == WR);
  assign bus.done         = done_wr_reg || drain_done;
  assign ram_write_enable = ram_we_reg;
  assign ram_address      = ram_addr_reg;
  assign ram_data_in      = ram_din_reg;
endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 The block SHALL have parameter ADDR, default 8, meaning RAM address width in bits.
REQ-002 The block SHALL have parameter DATA, default 8, meaning RAM data width in bits.
REQ-003 The block SHALL have parameter LEN_W, default 4, meaning burst-length field width; beats = req_len+1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  burst request offered.
REQ-008 req_ready  out  1  request accepted when both are high.
REQ-009 req_write  in  1  1 = write burst, 0 = read burst.
REQ-010 req_addr  in  ADDR  start address.
REQ-011 req_len  in  LEN_W  beats minus one.
REQ-012 wr_valid / wr_ready / wr_data  in / out / DATA  write-beat handshake.
REQ-013 rd_valid / rd_ready / rd_data  out / in / DATA  read-beat handshake.
REQ-014 done  out  1  one-cycle pulse at burst completion.
REQ-015 ram_write_enable / ram_address / ram_data_in  out  1 / ADDR / DATA  registered drive to the RAM.
REQ-016 ram_data_out  in  DATA  RAM read data, valid the cycle after the RAM samples a read address.

Function
REQ-017 The FSM SHALL have states IDLE, WR, RD, DRAIN.
REQ-018 req_ready SHALL be 1 only in IDLE; on handshake, latch addr, len and direction, then go to WR or RD.
REQ-019 In WR, wr_ready SHALL be 1; each wr handshake SHALL register ram_write_enable=1, ram_address=current, ram_data_in=wr_data for exactly one cycle.
REQ-020 Cycles in WR without wr_valid SHALL drive ram_write_enable=0, holding address.
REQ-021 The current address SHALL increment by 1 per beat modulo 2^ADDR (0xFF wraps to 0x00).
REQ-022 After the last write beat the FSM SHALL return to IDLE and pulse done in the cycle after the last ram_write_enable pulse.
REQ-023 In RD, one read SHALL be issued per cycle (ram_write_enable=0, ram_address=current) while fifo occupancy plus in-flight reads is less than 4.
REQ-024 In-flight tracking SHALL be a 2-stage shift register; ram_data_out SHALL be pushed into the response FIFO two cycles after issue.
REQ-025 After the last read issue, the FSM SHALL go to DRAIN; it SHALL remain there until in-flight reads are 0 and the FIFO is empty, then go to IDLE with done pulsed that cycle.
REQ-026 rd_valid SHALL equal FIFO non-empty, and rd_data SHALL be the FIFO head; the head pops on rd_valid&&rd_ready.
REQ-027 A push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-028 The FIFO SHALL never overflow, guaranteed by REQ-023.
REQ-029 The minimum read latency SHALL be rd_valid in the 3rd cycle after request acceptance; sustained throughput SHALL be 1 beat/cycle with rd_ready held high.
REQ-030 req_valid outside IDLE SHALL be ignored; wr_valid outside WR SHALL be ignored.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE and the FIFO and in-flight stages SHALL be cleared.
REQ-032 On rst, outputs SHALL be: req_ready=1 on the cycle after, wr_ready=0, rd_valid=0, done=0, ram_write_enable=0, ram_address=0, ram_data_in=0.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse and no further RAM write.

Structure
REQ-034 The package ram_pkg SHALL hold the FSM state enum, the default ADDR/DATA/LEN_W values, and the FIFO depth constant (4).
REQ-035 The response FIFO SHALL be the sub-module ram_rsp_fifo (depth 4, DATA wide, occupancy output).

Verification
REQ-036 Write burst addr 0x10, len 3, data A0..A3 -> RAM 0x10..0x13 = A0..A3; done pulses once; then read burst 0x10 len 3 -> rd_data A0,A1,A2,A3 on consecutive cycles.
REQ-037 Write at 0xFE, len 2, data 11,22,33 -> locations 0xFE, 0xFF, 0x00 written; read back matches in order.
REQ-038 Read len 7 with rd_ready low 10 cycles -> exactly 4 buffered, no issue beyond occupancy+in-flight=4, no loss; release -> 8 beats in order, done after last pop.
REQ-039 Write len 0 with wr_valid delayed 5 cycles -> ram_write_enable stays 0 until the handshake, then a single pulse; done follows next cycle.
REQ-040 rst asserted during beat 2 of a len-7 read -> rd_valid=0 next cycle, no done, req_ready=1; a following burst behaves normally.
